// File: rtl/ph_packetizer.sv
// Pulse-height packetizer: buffers 16-bit results in a small FIFO and streams
// HEADER/SEQ/MSB/LSB byte packets; define PH_PACKETIZER_CHECKSUM_EN to append an XOR checksum byte.
module ph_packetizer #(
  parameter int unsigned DEPTH  = 4,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ph_valid,
  input  logic [15:0] ph_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        ovf_clr,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef PH_PACKETIZER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_MSB, S_LSB, S_CKS} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_MSB, S_LSB} state_t;
`endif

  state_t      r_state;
  logic [15:0] r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [15:0] r_ph;
  logic [7:0]  r_seq;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic        r_overflow;
  logic [7:0]  r_drop_count;

  logic        w_empty;
  logic        w_full;
  logic        w_xfer;
  logic        w_last;
  logic        w_done;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [15:0] w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign w_xfer  = r_tx_valid && tx_ready;
`ifdef PH_PACKETIZER_CHECKSUM_EN
  assign w_last  = (r_state == S_CKS);
`else
  assign w_last  = (r_state == S_LSB);
`endif
  assign w_done  = w_last && w_xfer;
  // The head entry is latched whenever the FSM is about to start a packet.
  assign w_pop   = !w_empty && ((r_state == S_IDLE) || w_done);
  assign w_push  = ph_valid && (!w_full || w_pop);
  assign w_drop  = ph_valid && w_full && !w_pop;

  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign busy       = !w_empty || (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= ph_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      r_drop_count <= ovf_clr ? 8'd1 :
                      (r_drop_count == 8'hFF) ? 8'hFF : r_drop_count + 8'd1;
    end else if (ovf_clr) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ph       <= '0;
      r_seq      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_done) begin
      r_seq <= r_seq + 8'd1;
      if (!w_empty) begin
        r_ph      <= w_head;
        r_state   <= S_HDR;
        r_tx_data <= HEADER;
      end else begin
        r_state    <= S_IDLE;
        r_tx_valid <= 1'b0;
        r_tx_data  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: if (!w_empty) begin
          r_ph       <= w_head;
          r_state    <= S_HDR;
          r_tx_valid <= 1'b1;
          r_tx_data  <= HEADER;
        end
        S_HDR: if (w_xfer) begin
          r_state   <= S_SEQ;
          r_tx_data <= r_seq;
        end
        S_SEQ: if (w_xfer) begin
          r_state   <= S_MSB;
          r_tx_data <= r_ph[15:8];
        end
        S_MSB: if (w_xfer) begin
          r_state   <= S_LSB;
          r_tx_data <= r_ph[7:0];
        end
`ifdef PH_PACKETIZER_CHECKSUM_EN
        S_LSB: if (w_xfer) begin
          r_state   <= S_CKS;
          r_tx_data <= r_seq ^ r_ph[15:8] ^ r_ph[7:0];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ph_packetizer.sv
// Bench for ph_packetizer: directed and random steps against a queue-based packet model.
module tb_ph_packetizer;

  localparam int DEPTH = 4;
  localparam logic [7:0] HEADER = 8'hA5;
`ifdef PH_PACKETIZER_CHECKSUM_EN
  localparam int PLEN = 5;
`else
  localparam int PLEN = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ph_valid = 1'b0;
  logic [15:0] ph_data = '0;
  logic        tx_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        busy;

  ph_packetizer #(.DEPTH(DEPTH), .HEADER(HEADER)) dut (
    .clk(clk), .reset_n(reset_n), .ph_valid(ph_valid), .ph_data(ph_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .ovf_clr(ovf_clr), .overflow(overflow), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_fifo[$];
  logic [7:0]  m_pkt[$];
  logic [7:0]  m_seq;
  bit          m_ovf;
  int          m_drops;
  logic [7:0]  tx_log[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_fifo.delete();
    m_pkt.delete();
    m_seq   = '0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endfunction

  function automatic void m_build(input logic [15:0] ph);
    m_pkt.push_back(HEADER);
    m_pkt.push_back(m_seq);
    m_pkt.push_back(ph[15:8]);
    m_pkt.push_back(ph[7:0]);
    if (PLEN == 5) m_pkt.push_back(m_seq ^ ph[15:8] ^ ph[7:0]);
  endfunction

  // One clock edge of the packet-level model.
  function automatic void m_step(input bit v, input logic [15:0] d, input bit r, input bit c);
    bit xfer, fin, pop, full, drop;
    xfer = (m_pkt.size() != 0) && r;
    fin  = xfer && (m_pkt.size() == 1);
    pop  = (m_fifo.size() != 0) && ((m_pkt.size() == 0) || fin);
    full = (m_fifo.size() == DEPTH);
    drop = v && full && !pop;
    if (xfer) void'(m_pkt.pop_front());
    if (fin) m_seq = m_seq + 8'd1;
    if (pop) m_build(m_fifo.pop_front());
    if (v && !drop) m_fifo.push_back(d);
    if (drop) begin
      m_ovf   = 1'b1;
      m_drops = c ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
    end else if (c) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end
  endfunction

  task automatic check_all();
    chk("tx_valid", 16'(tx_valid), 16'(m_pkt.size() != 0));
    if (m_pkt.size() != 0) chk("tx_data", 16'(tx_data), 16'(m_pkt[0]));
    chk("busy", 16'(busy), 16'((m_pkt.size() != 0) || (m_fifo.size() != 0)));
    chk("overflow", 16'(overflow), 16'(m_ovf));
    chk("drop_count", 16'(drop_count), 16'(m_drops));
  endtask

  task automatic tick(input bit v, input logic [15:0] d, input bit r, input bit c);
    ph_valid = v;
    ph_data  = d;
    tx_ready = r;
    ovf_clr  = c;
    if (tx_valid && r) tx_log.push_back(tx_data);
    @(posedge clk);
    m_step(v, d, r, c);
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    #2;
    reset_n  = 1'b0;
    ph_valid = 1'b1;
    ph_data  = 16'hDEAD;
    tx_ready = 1'b0;
    ovf_clr  = 1'b0;
    m_reset();
    #1;
    chk("rst_tx_valid", 16'(tx_valid), 16'd0);
    chk("rst_tx_data", 16'(tx_data), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    chk("rst_drop_count", 16'(drop_count), 16'd0);
    @(posedge clk);
    #1;
    ph_valid = 1'b0;
    reset_n  = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_single[5];
    bit         done;
    exp_single[0] = 8'hA5; exp_single[1] = 8'h00; exp_single[2] = 8'h12;
    exp_single[3] = 8'h34; exp_single[4] = 8'h26;

    apply_reset();

    // Single result at full rate
    tx_log.delete();
    tick(1'b1, 16'h1234, 1'b1, 1'b0);
    drain(PLEN + 3);
    chk("single_len", 16'(tx_log.size()), 16'(PLEN));
    for (int i = 0; i < PLEN; i++) chk("single_byte", 16'(tx_log[i]), 16'(exp_single[i]));
    chk("single_busy", 16'(busy), 16'd0);

    // Backpressure with ready pattern 1,0,0
    for (int i = 0; i < 40; i++)
      tick((i == 0) || (i == 2) || (i == 9), 16'($urandom), (i % 3) == 0, 1'b0);

    // Overflow and ovf_clr interaction
    apply_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b0);
    chk("ovf_after6", 16'(overflow), 16'd1);
    chk("drops_after6", 16'(drop_count), 16'd1);
    tick(1'b1, 16'($urandom), 1'b0, 1'b0);
    tick(1'b1, 16'($urandom), 1'b0, 1'b0);
    chk("drops_after8", 16'(drop_count), 16'd3);
    tick(1'b1, 16'($urandom), 1'b0, 1'b1);
    chk("clr_drop_same_edge", 16'(drop_count), 16'd1);
    tick(1'b0, '0, 1'b0, 1'b1);
    chk("clr_only", 16'(drop_count), 16'd0);
    tx_log.delete();
    drain(5 * PLEN + 5);
    chk("ovf_pkt_bytes", 16'(tx_log.size()), 16'(5 * PLEN));
    for (int k = 0; k < 5; k++) chk("ovf_pkt_seq", 16'(tx_log[k * PLEN + 1]), 16'(k));

    // Full FIFO with a push on the final-byte edge
    for (int i = 0; i < 5; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b0);
    tx_log.delete();
    done = 1'b0;
    for (int i = 0; i < 3 * PLEN && !done; i++) begin
      if ((m_pkt.size() == 1) && (m_fifo.size() == DEPTH)) begin
        tick(1'b1, 16'hBEEF, 1'b1, 1'b0);
        done = 1'b1;
      end else begin
        tick(1'b0, '0, 1'b1, 1'b0);
      end
    end
    drain(6 * PLEN + 4);
    chk("fwp_no_drop", 16'(drop_count), 16'd0);
    chk("fwp_len", 16'(tx_log.size()), 16'(6 * PLEN));
    chk("fwp_last_msb", 16'(tx_log[5 * PLEN + 2]), 16'hBE);
    chk("fwp_last_lsb", 16'(tx_log[5 * PLEN + 3]), 16'hEF);

    // Random traffic
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);
    drain(6 * PLEN + 4);

    // SEQ wraps after 256 packets
    apply_reset();
    tx_log.delete();
    for (int i = 0; i < 257; i++) begin
      tick(1'b1, 16'(i), 1'b1, 1'b0);
      drain(PLEN + 1);
    end
    chk("wrap_len", 16'(tx_log.size()), 16'(257 * PLEN));
    chk("wrap_seq_ff", 16'(tx_log[255 * PLEN + 1]), 16'hFF);
    chk("wrap_seq_00", 16'(tx_log[256 * PLEN + 1]), 16'h00);

    // Reset while the MSB byte is on the bus
    tick(1'b1, 16'hCAFE, 1'b1, 1'b0);
    for (int i = 0; i < 10 && (m_pkt.size() != PLEN - 2); i++) tick(1'b0, '0, 1'b1, 1'b0);
    tx_ready = 1'b0;
    chk("mid_msb_byte", 16'(tx_data), 16'hCA);
    apply_reset();
    tx_log.delete();
    tick(1'b1, 16'h5A5A, 1'b1, 1'b0);
    drain(PLEN + 3);
    chk("post_rst_len", 16'(tx_log.size()), 16'(PLEN));
    chk("post_rst_seq", 16'(tx_log[1]), 16'h00);
    chk("post_rst_msb", 16'(tx_log[2]), 16'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
